jt12_slot_seq: RTL and testbench
================================

# jt12_slot_seq

Slot sequencer for the FM core: walks the 24 operator slots (6 channels × 4 operators) one step per clock-enable and publishes the current channel/operator indices that the mod-6 channel adders downstream consume. It guarantees those adders only ever see channel values 0–5 and provides a registered look-ahead channel index. It also hosts the register-write slot matcher: a held write request is parked until the sequencer reaches the addressed channel/operator slot, then acknowledged.

## Interface
- CH_AHEAD, default 1: look-ahead distance for ch_plus; legal range 0–5.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clk_en  in  1  slot advance strobe; sequencer and write matcher act only on edges where it is 1.
- cur_ch  out  3  current channel, 0–5 only.
- cur_op  out  2  current operator, 0–3.
- slot  out  5  linear slot index = cur_op*6 + cur_ch, 0–23.
- zero  out  1  high while slot == 0.
- ch_plus  out  3  (cur_ch + CH_AHEAD) mod 6, registered.
- wr_req  in  1  write request; sampled on every clk edge, independent of clk_en.
- wr_ch  in  3  target channel; values 6–7 are illegal.
- wr_op  in  2  target operator.
- wr_busy  out  1  request parked, waiting for its slot.
- wr_hit  out  1  busy and (cur_ch, cur_op) equal the parked target.
- wr_done  out  1  one-clk pulse: parked write retired.
- wr_err  out  1  one-clk pulse: request rejected (wr_ch > 5).

## Operation
- Counter: on clk_en edge, cur_ch increments; 5 → 0 wraps and increments cur_op (3 → 0 wraps). slot increments 0–23, 23 → 0. Values 6/7 never appear on cur_ch.
- ch_plus: computed from next cur_ch with 4-bit intermediate, subtract 6 when ≥ 6; loaded on the same edge as cur_ch.
- zero: registered, loaded with (next slot == 0).
- Write matcher, two states:
  - IDLE: on a clk edge with wr_req=1: if wr_ch ≤ 5, capture wr_ch/wr_op into target, go BUSY (wr_busy=1 next cycle); if wr_ch > 5, stay IDLE and pulse wr_err for one clk.
  - BUSY: wr_req ignored. wr_hit = busy ∧ cur_ch==tgt_ch ∧ cur_op==tgt_op (decoded from registers, no extra delay). On a clk_en edge with wr_hit=1: go IDLE, pulse wr_done for one clk.
- Request captured while cur already equals target: wr_hit rises in the cycle after capture; retires at the next clk_en edge.
- wr_done edge and a new wr_req on the same edge: new request not accepted (state was BUSY at that edge); accepted on the first edge with state IDLE.
- Reset (any time, including mid-wait): counters, target, and state cleared immediately; parked request is dropped without wr_done.

## Timing
- Reset values: cur_ch=0, cur_op=0, slot=0, zero=1, ch_plus=CH_AHEAD, wr_busy=0, wr_hit=0, wr_done=0, wr_err=0.
- All outputs are registered or decoded only from registers; no combinational path from any input to any output.
- Counter latency: outputs update on the clk_en edge itself; with clk_en tied high, full cycle = 24 clks.
- Write latency: wr_busy rises 1 clk after the accepting edge; wr_done at most 24 clk_en periods + 1 clk after acceptance; wr_err 1 clk after sampling.
- wr_hit stays high for exactly one clk_en period per retired write.

## Test plan
- Reset release, clk_en=1 for 30 clks → slot 0..23,0..5; cur_ch 0..5 repeating; cur_op steps every 6; zero high at clks 0 and 24 only.
- CH_AHEAD=5, clk_en=1 → ch_plus = 5,0,1,2,3,4 as cur_ch = 0..5; never ≥ 6.
- clk_en toggling 1-of-3 → outputs advance only on enabled edges; wr_req pulse with wr_ch=3, wr_op=2 at slot 0 → wr_busy next clk, wr_hit while slot=15, wr_done 1 clk after that clk_en edge.
- wr_req with wr_ch=7 → wr_err one-clk pulse, wr_busy stays 0; wr_req with target = current slot → wr_done after next clk_en edge.
- wr_req held high continuously with target ch=1, op=0 → back-to-back accept, retire, re-accept; wr_done pulses exactly once per 24-slot cycle.
- rst_n low for 1 clk while wr_busy=1 at slot 17 → all outputs at reset values immediately, no wr_done; sequence restarts at slot 0.

Source files
------------

// File: rtl/jt12_slot_seq.sv
// Walks the 24 FM operator slots one step per clk_en and parks register writes until their slot comes round.
// All outputs come straight from flops or from a compare of flops; the write path holds one request at a time.
module jt12_slot_seq #(
  parameter int CH_AHEAD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  output logic [2:0] cur_ch,
  output logic [1:0] cur_op,
  output logic [4:0] slot,
  output logic       zero,
  output logic [2:0] ch_plus,
  input  logic       wr_req,
  input  logic [2:0] wr_ch,
  input  logic [1:0] wr_op,
  output logic       wr_busy,
  output logic       wr_hit,
  output logic       wr_done,
  output logic       wr_err
);

  localparam logic [3:0] AHEAD     = 4'(CH_AHEAD);
  localparam logic [2:0] AHEAD_RST = 3'(CH_AHEAD);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wr_state_e;

  logic [2:0] cur_ch_q, cur_ch_d;
  logic [1:0] cur_op_q, cur_op_d;
  logic [4:0] slot_q, slot_d;
  logic       zero_q, zero_d;
  logic [2:0] ch_plus_q, ch_plus_d;
  logic [3:0] ch_sum;

  wr_state_e  state_q, state_d;
  logic [2:0] tgt_ch_q, tgt_ch_d;
  logic [1:0] tgt_op_q, tgt_op_d;
  logic       wr_done_q, wr_done_d;
  logic       wr_err_q, wr_err_d;
  logic       hit;

  always_comb begin
    cur_ch_d = cur_ch_q;
    cur_op_d = cur_op_q;
    slot_d   = slot_q;
    if (clk_en) begin
      if (cur_ch_q == 3'd5) begin
        cur_ch_d = 3'd0;
        cur_op_d = cur_op_q + 2'd1;
      end else begin
        cur_ch_d = cur_ch_q + 3'd1;
      end
      slot_d = (slot_q == 5'd23) ? 5'd0 : slot_q + 5'd1;
    end
    // Widen before adding so 5 + 5 cannot wrap before the mod-6 fold.
    ch_sum    = {1'b0, cur_ch_d} + AHEAD;
    ch_plus_d = (ch_sum >= 4'd6) ? 3'(ch_sum - 4'd6) : ch_sum[2:0];
    zero_d    = (slot_d == 5'd0);
  end

  assign hit = (state_q == BUSY) && (cur_ch_q == tgt_ch_q) && (cur_op_q == tgt_op_q);

  always_comb begin
    state_d   = state_q;
    tgt_ch_d  = tgt_ch_q;
    tgt_op_d  = tgt_op_q;
    wr_done_d = 1'b0;
    wr_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          if (wr_ch <= 3'd5) begin
            tgt_ch_d = wr_ch;
            tgt_op_d = wr_op;
            state_d  = BUSY;
          end else begin
            wr_err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        // Requests arriving while parked are ignored, including on the retire edge.
        if (clk_en && hit) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_q  <= 3'd0;
      cur_op_q  <= 2'd0;
      slot_q    <= 5'd0;
      zero_q    <= 1'b1;
      ch_plus_q <= AHEAD_RST;
      state_q   <= IDLE;
      tgt_ch_q  <= 3'd0;
      tgt_op_q  <= 2'd0;
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      cur_ch_q  <= cur_ch_d;
      cur_op_q  <= cur_op_d;
      slot_q    <= slot_d;
      zero_q    <= zero_d;
      ch_plus_q <= ch_plus_d;
      state_q   <= state_d;
      tgt_ch_q  <= tgt_ch_d;
      tgt_op_q  <= tgt_op_d;
      wr_done_q <= wr_done_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign cur_ch  = cur_ch_q;
  assign cur_op  = cur_op_q;
  assign slot    = slot_q;
  assign zero    = zero_q;
  assign ch_plus = ch_plus_q;
  assign wr_busy = (state_q == BUSY);
  assign wr_hit  = hit;
  assign wr_done = wr_done_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_jt12_slot_seq.sv
// Scoreboarded bench for jt12_slot_seq: stimulus pushes expected snapshots, a negedge monitor pops and compares.
module tb_jt12_slot_seq;

  logic       clk, rst_n, clk_en, wr_req;
  logic [2:0] wr_ch;
  logic [1:0] wr_op;

  logic [2:0] cur_ch, ch_plus, cur_ch5, ch_plus5;
  logic [1:0] cur_op, cur_op5;
  logic [4:0] slot, slot5;
  logic       zero, wr_busy, wr_hit, wr_done, wr_err;
  logic       zero5, wr_busy5, wr_hit5, wr_done5, wr_err5;

  jt12_slot_seq dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .cur_ch(cur_ch), .cur_op(cur_op), .slot(slot), .zero(zero), .ch_plus(ch_plus),
    .wr_req(wr_req), .wr_ch(wr_ch), .wr_op(wr_op),
    .wr_busy(wr_busy), .wr_hit(wr_hit), .wr_done(wr_done), .wr_err(wr_err)
  );

  jt12_slot_seq #(.CH_AHEAD(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .cur_ch(cur_ch5), .cur_op(cur_op5), .slot(slot5), .zero(zero5), .ch_plus(ch_plus5),
    .wr_req(wr_req), .wr_ch(wr_ch), .wr_op(wr_op),
    .wr_busy(wr_busy5), .wr_hit(wr_hit5), .wr_done(wr_done5), .wr_err(wr_err5)
  );

  typedef struct {
    int slot;
    bit busy;
    bit hit;
    bit done;
    bit err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   count_done = 0;

  // Reference state: expected slot after the last edge, and the parked target as a linear slot.
  int   m_slot = 0;
  bit   m_busy = 0;
  int   m_tgt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: stimulus did not complete at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input bit done, input bit err);
    exp_t e;
    e.slot = m_slot;
    e.busy = m_busy;
    e.hit  = m_busy && (m_slot == m_tgt);
    e.done = done;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic step(input bit en, input bit req, input int ch, input int op);
    bit pre_hit;
    bit done;
    bit err;
    clk_en = en;
    wr_req = req;
    wr_ch  = 3'(ch);
    wr_op  = 2'(op);
    @(posedge clk);
    pre_hit = m_busy && (m_slot == m_tgt);
    done = 1'b0;
    err  = 1'b0;
    if (!m_busy) begin
      if (req) begin
        if (ch <= 5) begin
          m_busy = 1'b1;
          m_tgt  = op * 6 + ch;
        end else begin
          err = 1'b1;
        end
      end
    end else if (en && pre_hit) begin
      m_busy = 1'b0;
      done   = 1'b1;
    end
    if (en) m_slot = (m_slot + 1) % 24;
    push_exp(done, err);
    #1;
  endtask

  always @(negedge clk) begin
    if (count_done && wr_done) done_cnt++;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("slot",     int'(slot),     e.slot);
      chk("cur_ch",   int'(cur_ch),   e.slot % 6);
      chk("cur_op",   int'(cur_op),   e.slot / 6);
      chk("zero",     int'(zero),     int'(e.slot == 0));
      chk("ch_plus1", int'(ch_plus),  (e.slot % 6 + 1) % 6);
      chk("ch_plus5", int'(ch_plus5), (e.slot % 6 + 5) % 6);
      chk("wr_busy",  int'(wr_busy),  int'(e.busy));
      chk("wr_hit",   int'(wr_hit),   int'(e.hit));
      chk("wr_done",  int'(wr_done),  int'(e.done));
      chk("wr_err",   int'(wr_err),   int'(e.err));
    end
  end

  initial begin
    rst_n  = 1'b0;
    clk_en = 1'b0;
    wr_req = 1'b0;
    wr_ch  = 3'd0;
    wr_op  = 2'd0;
    #1;
    push_exp(1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Free-running sweep past one full 24-slot turn.
    for (int i = 0; i < 30; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 18; i++) step(1, 0, 0, 0);

    // Write to ch3/op2 (slot 15) accepted at slot 0, with clk_en on one edge in three.
    step(0, 1, 3, 2);
    for (int i = 0; i < 51; i++) step(i % 3 == 0, 0, 0, 0);

    // Illegal channel: error pulse only, matcher stays idle.
    step(1, 1, 7, 0);
    step(1, 0, 0, 0);

    // Target equals the current slot (19 = op3/ch1) with clk_en low on the capture edge.
    step(0, 1, 1, 3);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Held request for ch1/op0: retires at steps 5, 29 and 53 of 72.
    done_cnt   = 0;
    count_done = 1'b1;
    for (int i = 0; i < 72; i++) step(1, 1, 1, 0);
    @(negedge clk);
    #1;
    count_done = 1'b0;
    chk("held_done_count", done_cnt, 3);

    // Drain the leftover write, then park one for slot 0 and stop at slot 17.
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 0);
    chk("pre_reset_slot", int'(slot), 17);
    chk("pre_reset_busy", int'(wr_busy), 1);

    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_slot", int'(slot), 0);
    chk("arst_busy", int'(wr_busy), 0);
    chk("arst_zero", int'(zero), 1);
    chk("arst_ch_plus5", int'(ch_plus5), 5);
    m_slot = 0;
    m_busy = 1'b0;
    push_exp(1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
